// File: rtl/res_drain.sv
// Result drain stage: snapshots the array's result matrix and
// streams it out row-major over a valid/ready handshake.
module res_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int MAT_WIDTH  = 8,
  parameter int IDX_WIDTH  = (MAT_WIDTH > 1) ? $clog2(MAT_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ipC [0:MAT_WIDTH-1][0:MAT_WIDTH-1],
  input  logic                  arrValid,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] outData,
  output logic [IDX_WIDTH-1:0]  outRow,
  output logic [IDX_WIDTH-1:0]  outCol,
  output logic                  outLast,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  busy
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX =
    IDX_WIDTH'(MAT_WIDTH - 1);

  state_e                state_q, state_d;
  logic                  armed_q, armed_d;
  logic                  ack_q, ack_d;
  logic [IDX_WIDTH-1:0]  row_q, row_d;
  logic [IDX_WIDTH-1:0]  col_q, col_d;
  logic [DATA_WIDTH-1:0] mat_q [0:MAT_WIDTH-1][0:MAT_WIDTH-1];
  logic [DATA_WIDTH-1:0] mat_d [0:MAT_WIDTH-1][0:MAT_WIDTH-1];
  logic                  streaming;
  logic                  at_last;

  assign streaming = (state_q == STREAM);
  assign at_last   = (row_q == LAST_IDX) && (col_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    ack_d   = 1'b0;
    row_d   = row_q;
    col_d   = col_q;
    mat_d   = mat_q;
    // Re-arm on any low cycle so a held-high valid captures only once.
    if (!arrValid) armed_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (arrValid && armed_q) begin
          mat_d   = ipC;
          armed_d = 1'b0;
          ack_d   = 1'b1;
          row_d   = '0;
          col_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (outReady) begin
          if (at_last) begin
            row_d   = '0;
            col_d   = '0;
            state_d = IDLE;
          end else if (col_q == LAST_IDX) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      armed_q <= 1'b1;
      ack_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      ack_q   <= ack_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Buffer contents are only meaningful while streaming.
  always_ff @(posedge clk) begin
    mat_q <= mat_d;
  end

  assign ack      = ack_q;
  assign busy     = streaming;
  assign outValid = streaming;
  assign outLast  = streaming && at_last;
  assign outRow   = row_q;
  assign outCol   = col_q;
  assign outData  = streaming ? mat_q[row_q][col_q] : '0;

endmodule

// File: tb/tb_res_drain.sv
// Bench for res_drain: M=4 and M=1 instances against a
// linear-position reference model with random stimulus.
module tb_res_drain;

  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] ipc0 [0:3][0:3];
  logic [DW-1:0] ipc1 [0:0][0:0];
  logic          av0, av1, rdy0, rdy1;
  logic          ack0, ack1, val0, val1;
  logic          last0, last1, busy0, busy1;
  logic [DW-1:0] dat0, dat1;
  logic [1:0]    row0, col0;
  logic          row1, col1;

  res_drain #(.DATA_WIDTH(DW), .MAT_WIDTH(4)) dut0 (
    .clk(clk), .rst(rst), .ipC(ipc0), .arrValid(av0),
    .ack(ack0), .outData(dat0), .outRow(row0),
    .outCol(col0), .outLast(last0), .outValid(val0),
    .outReady(rdy0), .busy(busy0)
  );

  res_drain #(.DATA_WIDTH(DW), .MAT_WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .ipC(ipc1), .arrValid(av1),
    .ack(ack1), .outData(dat1), .outRow(row1),
    .outCol(col1), .outLast(last1), .outValid(val1),
    .outReady(rdy1), .busy(busy1)
  );

  // Model: a captured matrix is a flat list of M*M elements and
  // pos is how far the stream has progressed through it.
  int mm [2] = '{4, 1};
  bit act_m [2];
  int pos_m [2];
  bit armed_m [2];
  bit ack_m [2];
  int cap_m [2][16];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit av, rdy, cap;
    int n;
    for (int k = 0; k < 2; k++) begin
      av  = (k == 0) ? av0 : av1;
      rdy = (k == 0) ? rdy0 : rdy1;
      n   = mm[k] * mm[k];
      if (!rst) begin
        act_m[k]   = 1'b0;
        pos_m[k]   = 0;
        armed_m[k] = 1'b1;
        ack_m[k]   = 1'b0;
      end else begin
        cap      = !act_m[k] && av && armed_m[k];
        ack_m[k] = cap;
        if (cap) begin
          if (k == 0) begin
            for (int r = 0; r < 4; r++)
              for (int c = 0; c < 4; c++)
                cap_m[0][r*4+c] = int'(ipc0[r][c]);
          end else begin
            cap_m[1][0] = int'(ipc1[0][0]);
          end
          act_m[k]   = 1'b1;
          pos_m[k]   = 0;
          armed_m[k] = 1'b0;
        end else if (act_m[k] && rdy) begin
          if (pos_m[k] == n - 1) begin
            act_m[k] = 1'b0;
            pos_m[k] = 0;
          end else begin
            pos_m[k]++;
          end
        end
        if (!av) armed_m[k] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] o_ack, o_val, o_last, o_busy;
    logic [31:0] o_dat, o_row, o_col;
    int n, p;
    bit a;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        o_ack = 32'(ack0);  o_val = 32'(val0);
        o_last = 32'(last0); o_busy = 32'(busy0);
        o_dat = 32'(dat0);  o_row = 32'(row0);
        o_col = 32'(col0);
      end else begin
        o_ack = 32'(ack1);  o_val = 32'(val1);
        o_last = 32'(last1); o_busy = 32'(busy1);
        o_dat = 32'(dat1);  o_row = 32'(row1);
        o_col = 32'(col1);
      end
      n = mm[k] * mm[k];
      p = pos_m[k];
      a = act_m[k];
      chk($sformatf("ack%0d", k), o_ack, 32'(ack_m[k]));
      chk($sformatf("valid%0d", k), o_val, 32'(a));
      chk($sformatf("busy%0d", k), o_busy, 32'(a));
      chk($sformatf("last%0d", k), o_last,
          32'(a && p == n - 1));
      chk($sformatf("data%0d", k), o_dat,
          a ? 32'(cap_m[k][p]) : 32'd0);
      chk($sformatf("row%0d", k), o_row,
          a ? 32'(p / mm[k]) : 32'd0);
      chk($sformatf("col%0d", k), o_col,
          a ? 32'(p % mm[k]) : 32'd0);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_mat();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        ipc0[r][c] = DW'($urandom);
    ipc1[0][0] = DW'($urandom);
  endtask

  initial begin
    rst  = 1'b0;
    av0  = 1'b1;
    av1  = 1'b1;
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        ipc0[r][c] = DW'(16 * r + c);
    ipc1[0][0] = 8'h5a;

    // reset with valid held high
    repeat (2) step();

    // release: one capture despite valid held high
    rst = 1'b1;
    repeat (25) step();

    // drop valid one cycle, then recapture under backpressure
    av0 = 1'b0;
    av1 = 1'b0;
    step();
    av0 = 1'b1;
    av1 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rdy0 = (i % 4 == 0) || (i % 4 == 3);
      rdy1 = 1'($urandom);
      rand_mat();
      step();
    end

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 39) != 0);
      av0  = ($urandom_range(0, 3) != 0);
      av1  = ($urandom_range(0, 3) != 0);
      rdy0 = ($urandom_range(0, 2) != 0);
      rdy1 = 1'($urandom);
      rand_mat();
      step();
    end

    // reset two beats into a stream
    rst  = 1'b1;
    av0  = 1'b0;
    av1  = 1'b0;
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    step();
    av0 = 1'b1;
    rand_mat();
    repeat (3) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    av0 = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/res_drain.md
# res_drain

Downstream drain stage for the systolic matrix multiplier. It captures the full MAT_WIDTH×MAT_WIDTH result matrix when the array flags it valid and returns a one-cycle acknowledge so the array can leave its DONE state. It then streams the captured elements out one per beat, row-major, over a valid/ready interface. This frees the array to begin the next multiplication while the previous result drains.

## Interface

Parameters:
- DATA_WIDTH, 8, width of one matrix element; must match the array.
- MAT_WIDTH, 8, matrix dimension M (M ≥ 1); must match the array.
- IDX_WIDTH, max(1, ceil(log2(MAT_WIDTH))), width of the row and column indices (derived).

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- ipC  in  DATA_WIDTH × [0:M-1][0:M-1]  result matrix from the array.
- arrValid  in  1  result-matrix-valid from the array; held high until acknowledged.
- ack  out  1  one-cycle acknowledge to the array.
- outData  out  DATA_WIDTH  current element.
- outRow  out  IDX_WIDTH  row index of outData.
- outCol  out  IDX_WIDTH  column index of outData.
- outLast  out  1  high on the element (M-1, M-1).
- outValid  out  1  outData, outRow, outCol and outLast are valid.
- outReady  in  1  downstream accepts the beat.
- busy  out  1  high while a captured matrix is draining.

## Operation

- States: IDLE and STREAM.
- Internal state: a capture buffer of M×M×DATA_WIDTH, row/column counters, and an armed flag.
- IDLE, with arrValid=1 and armed=1 at a rising edge:
  - copy all of ipC into the buffer;
  - clear armed;
  - set row=col=0;
  - register ack=1;
  - go to STREAM.
- IDLE, with arrValid=1 and armed=0: no capture.
- armed is set on any edge where arrValid=0. This guarantees exactly one capture per arrValid assertion, even if arrValid stays high.
- STREAM:
  - outValid=1;
  - outData=buffer[row][col];
  - outLast=(row==M-1 && col==M-1).
- A beat transfers on an edge where outValid && outReady.
- On each transfer:
  - col increments;
  - when col==M-1, col wraps to 0 and row increments;
  - on the transfer with outLast=1, go to IDLE and clear the counters.
- Stall: while outValid && !outReady, all out* signals hold stable.
- ipC and arrValid are ignored in STREAM. The buffer is never overwritten mid-drain.
- busy=(state==STREAM).
- M=1: one beat, with outLast=1 on that beat.

## Timing

- Reset: on an edge with rst=0:
  - state=IDLE, armed=1, row=col=0;
  - ack=0, outValid=0, outLast=0, busy=0, outData=0, outRow=0, outCol=0.
- Reset dominates every other event on the same edge.
- Reset mid-STREAM discards the buffer. No further beats are produced.
- Capture at edge E:
  - ack=1 and outValid=1 (element (0,0)) in the cycle after E;
  - ack returns to 0 one cycle later, regardless of outReady.
- With outReady held at 1:
  - M*M consecutive beats;
  - outValid falls in the cycle after the last transfer.
- The earliest next capture is the edge after the last transfer (IDLE), with arrValid=1 and armed=1.
- Minimum spacing between captures is M*M+1 cycles.
- outValid never depends combinationally on outReady. All outputs are registered or decoded from registered state.

## Test plan

- Reset behaviour: M=2, apply rst=0 for 2 cycles with arrValid=1 → all outputs 0. After release, capture on the first edge → one ack pulse, then beats (0,0),(0,1),(1,0),(1,1) with outLast on the 4th only.
- Data ordering: M=4, ipC[r][c]=16r+c, outReady=1 → 16 consecutive beats with outData=0,1,2,3,16,…,51, then outValid=0.
- Backpressure: M=2, toggle outReady 1,0,0,1,… → out* held stable during stalls, no beat lost or duplicated, 4 transfers total.
- Single capture per assertion: arrValid held high for 20 cycles with M=2 → exactly one ack and one 4-beat stream. Dropping arrValid for 1 cycle then reasserting → a second capture.
- Buffer isolation: change ipC and pulse arrValid mid-STREAM → the streamed values are the originally captured ones, with no extra ack.
- Reset mid-stream and M=1: rst=0 after beat 2 of 16 → outValid=0 the next cycle, then IDLE. With M=1, a single beat with outLast=1 and outRow=outCol=0.
